// File: rtl/float_int_pkg.sv
// float_int_pkg: shared types and width helpers for the float-to-int pipeline
package float_int_pkg;
  typedef enum logic {RND_TRUNC = 1'b0, RND_RNE = 1'b1} round_mode_e;
  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } fti_flags_t;
  localparam int GS_W = 2;
  function automatic int mag_w(input int int_w);
    return int_w + GS_W;
  endfunction
endpackage

// File: rtl/fti_shift_round.sv
// fti_shift_round: exact scaling of SIG by 2^(E-SIG_W) with truncate or round-to-nearest-even
module fti_shift_round
  import float_int_pkg::*;
#(
  parameter int EXP_W = 4,
  parameter int SIG_W = 8,
  parameter int INT_W = 8
) (
  input  logic [EXP_W-1:0]          e,
  input  logic [SIG_W-1:0]          sig,
  input  round_mode_e               mode,
  output logic [mag_w(INT_W)-1:0]   mag,
  output logic                      too_big,
  output logic                      frac_nz
);
  localparam int MAG_W = mag_w(INT_W);
  localparam int IP_W = 1 << EXP_W;
  localparam int FULL_W = SIG_W + IP_W;
  localparam int RW = (IP_W > MAG_W) ? IP_W + 1 : MAG_W + 1;
  logic [FULL_W-1:0] full;
  logic [IP_W-1:0] ip;
  logic [SIG_W-1:0] fr;
  logic [RW-1:0] rnd;
  logic up;
  assign full = {{IP_W{1'b0}}, sig} << e;
  assign {ip, fr} = full;
  assign up = mode == RND_RNE && fr[SIG_W-1] && (|fr[SIG_W-2:0] || ip[0]);
  assign rnd = RW'(ip) + RW'(up);
  assign mag = rnd[MAG_W-1:0];
  assign too_big = |rnd[RW-1:MAG_W];
  assign frac_nz = |fr;
endmodule

// File: rtl/float_to_int_pipe.sv
// float_to_int_pipe: three-stage stalling float-to-saturated-integer converter with exception flags
module float_to_int_pipe
  import float_int_pkg::*;
#(
  parameter int EXP_W = 4,
  parameter int SIG_W = 8,
  parameter int INT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EXP_W+SIG_W:0]     float_i,
  input  logic                     round_i,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [INT_W-1:0]         int_o,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     inexact,
  output logic                     out_valid,
  input  logic                     out_ready
);
  localparam int MAG_W = mag_w(INT_W);
  localparam logic [MAG_W-1:0] LIM = MAG_W'(1) << (INT_W - 1);
  logic en, v1, v2, v3, s1, s2, tb_c, tb2, fnz_c, fnz2, over;
  logic [EXP_W-1:0] e1;
  logic [SIG_W-1:0] sig1;
  round_mode_e m1;
  logic [MAG_W-1:0] mag_c, mag2;
  logic [INT_W-1:0] int_c;
  fti_flags_t fl_c, fl3;
  assign en = ~(v3 & ~out_ready);
  assign in_ready = en;
  assign out_valid = v3;
  assign {overflow, underflow, inexact} = {fl3.overflow, fl3.underflow, fl3.inexact};
  fti_shift_round #(.EXP_W(EXP_W), .SIG_W(SIG_W), .INT_W(INT_W)) u_sr (
    .e(e1), .sig(sig1), .mode(m1), .mag(mag_c), .too_big(tb_c), .frac_nz(fnz_c)
  );
  always_comb begin
    over = tb2 | (s2 ? mag2 > LIM : mag2 >= LIM);
    int_c = over ? (s2 ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}})
                 : (s2 ? -mag2[INT_W-1:0] : mag2[INT_W-1:0]);
    fl_c.overflow = over;
    fl_c.underflow = ~tb2 & (mag2 == '0) & fnz2;
    fl_c.inexact = fnz2 | over;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {v1, v2, v3, s1, s2, tb2, fnz2} <= '0;
      e1 <= '0;
      sig1 <= '0;
      m1 <= RND_TRUNC;
      mag2 <= '0;
      int_o <= '0;
      fl3 <= '0;
    end else if (en) begin
      v1 <= in_valid;
      s1 <= float_i[EXP_W+SIG_W];
      e1 <= float_i[SIG_W+:EXP_W];
      sig1 <= float_i[SIG_W-1:0];
      m1 <= round_mode_e'(round_i);
      v2 <= v1;
      s2 <= s1;
      mag2 <= mag_c;
      tb2 <= tb_c;
      fnz2 <= fnz_c;
      v3 <= v2;
      int_o <= int_c;
      fl3 <= fl_c;
    end
  end
endmodule

// File: tb/tb_float_to_int_pipe.sv
// tb_float_to_int_pipe: directed and random stream checks against an arithmetic reference model
module tb_float_to_int_pipe;
  logic clk = 0, rst = 1, round_i = 0, in_valid = 0, out_ready = 1;
  logic [12:0] float_i = '0;
  logic in_ready, overflow, underflow, inexact, out_valid;
  logic [7:0] int_o;
  int checks = 0, errors = 0;
  bit rnd_mode = 0, prev_stall = 0;
  logic [10:0] prev_out, q[$];
  typedef struct {logic [12:0] f; bit m; logic [10:0] exp;} vec_t;
  vec_t vt[12] = '{
    '{13'h04A0, 1'b0, {3'b000, 8'd10}},
    '{13'h04A0, 1'b1, {3'b000, 8'd10}},
    '{13'h02A0, 1'b0, {3'b001, 8'd2}},
    '{13'h02A0, 1'b1, {3'b001, 8'd2}},
    '{13'h02E0, 1'b1, {3'b001, 8'd4}},
    '{13'h12E0, 1'b1, {3'b001, 8'hFC}},
    '{13'h0880, 1'b0, {3'b101, 8'h7F}},
    '{13'h1880, 1'b0, {3'b000, 8'h80}},
    '{13'h0FFF, 1'b0, {3'b101, 8'h7F}},
    '{13'h0080, 1'b1, {3'b011, 8'h00}},
    '{13'h00C0, 1'b1, {3'b001, 8'h01}},
    '{13'h1900, 1'b0, {3'b000, 8'h00}}
  };
  float_to_int_pipe dut (
    .clk(clk), .rst(rst), .float_i(float_i), .round_i(round_i), .in_valid(in_valid),
    .in_ready(in_ready), .int_o(int_o), .overflow(overflow), .underflow(underflow),
    .inexact(inexact), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  function automatic logic [10:0] model(input logic [12:0] f, input bit m);
    longint v, ip, fr, sv;
    bit ov, un, ix;
    v = longint'(f[7:0]) * (longint'(1) << f[11:8]);
    ip = v / 256;
    fr = v % 256;
    if (m && (fr > 128 || (fr == 128 && ip % 2 == 1))) ip = ip + 1;
    sv = f[12] ? -ip : ip;
    ov = sv > 127 || sv < -128;
    sv = sv > 127 ? 127 : (sv < -128 ? -128 : sv);
    un = f[7:0] != 0 && ip == 0;
    ix = fr != 0 || ov;
    return {ov, un, ix, sv[7:0]};
  endfunction
  task automatic chk(input bit ok, input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic send(input logic [12:0] f, input bit m);
    int g = 0;
    float_i = f;
    round_i = m;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk(in_ready, "send_timeout", 32'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic drain();
    int g = 0;
    out_ready = 1;
    while ((q.size() != 0 || out_valid) && g < 50) begin
      @(posedge clk);
      #1 g++;
    end
    chk(q.size() == 0, "drain", 32'(q.size()), 0);
  endtask
  always @(negedge clk) begin
    logic [10:0] got, exp;
    got = {overflow, underflow, inexact, int_o};
    if (rst) begin
      q.delete();
      prev_stall = 0;
    end else begin
      chk(in_ready == !(out_valid && !out_ready), "in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (prev_stall) chk(got == prev_out, "stall_hold", 32'(got), 32'(prev_out));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk(0, "extra_output", 32'(got), 0);
        else begin
          exp = q.pop_front();
          chk(got == exp, "result", 32'(got), 32'(exp));
        end
      end
      if (in_valid && in_ready) q.push_back(model(float_i, round_i));
      prev_stall = out_valid && !out_ready;
      prev_out = got;
    end
  end
  always @(posedge clk) begin
    #1;
    if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk({out_valid, overflow, underflow, inexact, int_o} == '0, "reset_out", 32'({out_valid, overflow, underflow, inexact, int_o}), 0);
    chk(in_ready, "reset_ready", 32'(in_ready), 1);
    foreach (vt[i]) chk(model(vt[i].f, vt[i].m) == vt[i].exp, "model_pin", 32'(model(vt[i].f, vt[i].m)), 32'(vt[i].exp));
    float_i = vt[0].f;
    round_i = vt[0].m;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    chk(!out_valid, "lat1", 32'(out_valid), 0);
    @(posedge clk);
    #1 chk(!out_valid, "lat2", 32'(out_valid), 0);
    @(posedge clk);
    #1 chk(out_valid, "lat3", 32'(out_valid), 1);
    chk({overflow, underflow, inexact, int_o} == vt[0].exp, "lat_val", 32'({overflow, underflow, inexact, int_o}), 32'(vt[0].exp));
    drain();
    foreach (vt[i]) send(vt[i].f, vt[i].m);
    drain();
    rnd_mode = 1;
    for (int i = 0; i < 20; i++) begin
      send(13'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_mode = 0;
    drain();
    for (int i = 0; i < 3; i++) send(vt[i + 4].f, vt[i + 4].m);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk({out_valid, overflow, underflow, inexact, int_o} == '0, "midreset_out", 32'({out_valid, overflow, underflow, inexact, int_o}), 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 chk(!out_valid, "flushed", 32'(out_valid), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/float_to_int_pipe.md
# float_to_int_pipe

Parametrised, pipelined converter from the team's sign/exponent/significand float format to a saturating two's-complement integer. It accepts one sample per cycle over a valid/ready stream and offers truncate or round-to-nearest-even per sample. Exceptions are reported as overflow, underflow and inexact flags. It is the streaming successor to the combinational float-to-int converter and sits between float datapaths and integer consumers (display, DAC, accumulators).

## Interface
- EXP_W, default 4: exponent field width (unsigned)
- SIG_W, default 8: significand field width
- INT_W, default 8: output integer width, two's complement
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- float_i  input  1+EXP_W+SIG_W  {sign, exponent, significand}
- round_i  input  1  0 = truncate toward zero, 1 = round to nearest, ties to even
- in_valid  input  1  float_i/round_i valid
- in_ready  output  1  converter accepts this cycle
- int_o  output  INT_W  converted integer
- overflow  output  1  result saturated
- underflow  output  1  nonzero input rounded to 0
- inexact  output  1  int_o differs from exact value
- out_valid  output  1  int_o/flags valid
- out_ready  input  1  consumer accepts this cycle

## Operation
- Value = (-1)^sign × SIG × 2^(E − SIG_W), with E and SIG unsigned. There is no hidden bit. An unnormalised SIG uses the same formula.
- SIG == 0 gives int_o = 0 with all flags 0, for either sign.
- Magnitude is computed exactly for every E in 0..2^EXP_W−1. Left shift applies when E > SIG_W and right shift when E < SIG_W. No shifted-out bit may be lost before the overflow test.
- Truncate: the fraction is discarded from the magnitude, so rounding is toward zero for both signs.
- RNE: the decision uses the guard bit, the OR of the remaining bits (sticky) and the integer LSB. Rounding is symmetric in sign.
- Range is [−2^(INT_W−1), 2^(INT_W−1)−1]. The negative bound is exact and raises no flag.
- If the rounded magnitude is out of range, int_o saturates to the bound matching the sign, and overflow = 1 and inexact = 1.
- If the input is nonzero and the rounded magnitude is 0, int_o = 0, and underflow = 1 and inexact = 1.
- inexact = 1 whenever any fraction bit was nonzero, or on overflow.
- Flags are per sample, not sticky.

## Timing
- Three register stages:
  - S1: unpack, classify, capture round mode.
  - S2: shift, guard/sticky, round.
  - S3: saturate, negate, flags.
- Latency is 3 cycles from accepted input to out_valid when unstalled. Throughput is 1 sample per cycle.
- Pipeline control:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, a combinational path from out_ready.
  - A stall freezes all stages. Bubbles are not collapsed.
- Input transfers when in_valid & in_ready. Output transfers when out_valid & out_ready.
- While stalled, int_o and all flags hold stable.
- An output transfer and a new input in the same cycle both proceed, with no bubble.
- Reset:
  - All stage valid bits, out_valid, int_o and all flags go to 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-stream discards in-flight samples, and none emerges afterward.

## Structure
- Package float_int_pkg holds:
  - typedef round_mode_e {RND_TRUNC = 0, RND_RNE = 1};
  - struct fti_flags_t {overflow, underflow, inexact};
  - localparam helpers for the internal magnitude width, INT_W + 2 plus the guard and sticky bits.
- Sub-module fti_shift_round is combinational. It takes {E, SIG, mode} and returns {magnitude, too_big, frac_nonzero}. It is instantiated in S2. The top level holds the pipeline registers and handshake.

## Test plan
All cases use defaults 4/8/8; float_i is written as {s, E, SIG}.
- {0, 4, 0xA0}, either mode: 10 → int_o = 10, all flags 0, out_valid exactly 3 cycles after acceptance.
- {0, 2, 0xA0} = 2.5: truncate gives 2 with inexact, and RNE gives 2. {0, 2, 0xE0} = 3.5 with RNE gives 4 with inexact. {1, 2, 0xE0} with RNE gives −4 (0xFC).
- {0, 8, 0x80} = 128 gives 127 (0x7F) with overflow and inexact. {1, 8, 0x80} gives −128 (0x80) with no flags. {0, 15, 0xFF} gives 127 with overflow.
- {0, 0, 0x80} = 0.5: either mode gives 0 with underflow and inexact. {0, 0, 0xC0} = 0.75 with RNE gives 1 with inexact only. {1, 9, 0x00} gives 0 with no flags.
- Stream of 20 random samples with out_ready toggled pseudo-randomly:
  - Output order and values match the reference model.
  - No drop or duplicate.
  - int_o is stable during stalls.
  - in_ready = 0 exactly when out_valid & ~out_ready.
- rst asserted while 3 samples are in flight: next cycle out_valid = 0, int_o = 0, flags = 0, and none of those samples appears later.
